// File: rtl/rx_fifo_read_arbiter.sv
// Read-side arbiter for the UART receive FIFO: shares pops between the host read port
// and the BIST checker, returning each popped byte on a per-requester ack pulse.
module rx_fifo_read_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int POP_WAIT  = 2,
    parameter int CNT_BITS  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Host_Req,
    output logic                 Host_Ack,
    output logic [DATA_BITS-1:0] Host_Data,
    input  logic                 Bist_Req,
    output logic                 Bist_Ack,
    output logic [DATA_BITS-1:0] Bist_Data,
    input  logic                 Bist_Enable,
    input  logic                 FIFO_Empty,
    input  logic [DATA_BITS-1:0] FIFO_Data,
    output logic                 Read_Done,
    output logic                 BIST_Mode,
    output logic [1:0]           Grant,
    output logic [CNT_BITS-1:0]  Pop_Count
);

    localparam int WAIT_W = (POP_WAIT > 1) ? $clog2(POP_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POP_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        DELIVER,
        GAP
    } state_t;

    state_t state;
    state_t next_state;

    logic              empty_meta;
    logic              empty_s;
    logic [WAIT_W-1:0] wait_cnt;
    logic              gap_cnt;
    logic              last_bist;
    logic              host_elig;
    logic              bist_elig;
    logic [1:0]        winner;
    logic              start;
    logic              wait_done;
    logic              read_done_d;
    logic              host_ack_d;
    logic              bist_ack_d;

    // FIFO_Empty is asynchronous; preset to "empty" so nothing is popped straight out of reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            empty_meta <= 1'b1;
            empty_s    <= 1'b1;
        end else begin
            empty_meta <= FIFO_Empty;
            empty_s    <= empty_meta;
        end
    end

    assign host_elig = Host_Req;
    assign bist_elig = Bist_Req & BIST_Mode;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        winner = 2'b00;
        if (host_elig && bist_elig) begin
            winner = last_bist ? 2'b01 : 2'b10;
        end else if (host_elig) begin
            winner = 2'b01;
        end else if (bist_elig) begin
            winner = 2'b10;
        end
    end

    assign start     = (state == IDLE) && !empty_s && (winner != 2'b00);
    assign wait_done = (state == WAIT) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = POP;
            POP:     next_state = WAIT;
            WAIT:    if (wait_done) next_state = DELIVER;
            DELIVER: next_state = GAP;
            GAP:     if (gap_cnt) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded one cycle early and registered so the FIFO sees a clean strobe.
    always_comb begin
        read_done_d = start;
        host_ack_d  = wait_done && Grant[0];
        bist_ack_d  = wait_done && Grant[1];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Read_Done <= 1'b0;
            Host_Ack  <= 1'b0;
            Bist_Ack  <= 1'b0;
        end else begin
            Read_Done <= read_done_d;
            Host_Ack  <= host_ack_d;
            Bist_Ack  <= bist_ack_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_cnt <= '0;
            gap_cnt  <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            gap_cnt  <= (state == GAP) ? ~gap_cnt : 1'b0;
        end
    end

    // last_bist resets high so the host wins the first tie.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Grant     <= 2'b00;
            last_bist <= 1'b1;
            BIST_Mode <= 1'b0;
            Pop_Count <= '0;
        end else begin
            if (state == IDLE) begin
                BIST_Mode <= Bist_Enable;
            end
            if (start) begin
                Grant     <= winner;
                Pop_Count <= Pop_Count + 1'b1;
            end else if (state == DELIVER) begin
                last_bist <= Grant[1];
                Grant     <= 2'b00;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Host_Data <= '0;
            Bist_Data <= '0;
        end else begin
            if (wait_done && Grant[0]) begin
                Host_Data <= FIFO_Data;
            end
            if (wait_done && Grant[1]) begin
                Bist_Data <= FIFO_Data;
            end
        end
    end

endmodule

// File: tb/tb_rx_fifo_read_arbiter.sv
// Scoreboard bench for rx_fifo_read_arbiter: a small FIFO model feeds the DUT, expected
// acks are queued by the stimulus and checked by an independent monitor.
module tb_rx_fifo_read_arbiter;

    localparam int DATA_BITS = 8;
    localparam int POP_WAIT  = 2;
    localparam int CNT_BITS  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 host_req = 1'b0;
    logic                 bist_req = 1'b0;
    logic                 bist_enable = 1'b0;
    logic                 fifo_empty = 1'b1;
    logic [DATA_BITS-1:0] fifo_data = '0;
    logic                 host_ack;
    logic                 bist_ack;
    logic [DATA_BITS-1:0] host_data;
    logic [DATA_BITS-1:0] bist_data;
    logic                 read_done;
    logic                 bist_mode;
    logic [1:0]           grant;
    logic [CNT_BITS-1:0]  pop_count;

    rx_fifo_read_arbiter #(
        .DATA_BITS(DATA_BITS),
        .POP_WAIT (POP_WAIT),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Host_Req   (host_req),
        .Host_Ack   (host_ack),
        .Host_Data  (host_data),
        .Bist_Req   (bist_req),
        .Bist_Ack   (bist_ack),
        .Bist_Data  (bist_data),
        .Bist_Enable(bist_enable),
        .FIFO_Empty (fifo_empty),
        .FIFO_Data  (fifo_data),
        .Read_Done  (read_done),
        .BIST_Mode  (bist_mode),
        .Grant      (grant),
        .Pop_Count  (pop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 is_bist;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    exp_t                 exp_q[$];
    logic [DATA_BITS-1:0] fifo_q[$];
    int                   checks = 0;
    int                   errors = 0;
    int                   acks_seen = 0;
    int                   cycle = 0;
    int                   rd_cycle = 0;
    logic                 prev_rd = 1'b0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // The FIFO output register presents the popped byte once Read_Done is seen.
    task automatic step();
        @(negedge clk);
        if (rst_n && read_done && fifo_q.size() > 0) begin
            fifo_data = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_stimulus(input logic [DATA_BITS-1:0] data);
        fifo_q.push_back(data);
        fifo_empty = 1'b0;
    endtask

    task automatic expect_ack(input logic is_bist, input logic [DATA_BITS-1:0] data);
        exp_t e;
        e.is_bist = is_bist;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int n = 0;
        while (acks_seen < target && n < budget) begin
            step();
            n++;
        end
        check_output(name, int'(acks_seen >= target), 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        host_req = 1'b0;
        bist_req = 1'b0;
        steps(3);
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: pops the scoreboard on every ack and checks protocol rules.
    always @(negedge clk) begin
        cycle++;
        if (rst_n) begin
            if (read_done) begin
                check_output("read_done_back_to_back", int'(prev_rd), 0);
                rd_cycle = cycle;
            end
            prev_rd = read_done;
            if (host_ack || bist_ack) begin
                exp_t e;
                check_output("ack_exclusive", int'(host_ack && bist_ack), 0);
                check_output("ack_latency", cycle - rd_cycle, 1 + POP_WAIT);
                check_output("ack_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output("ack_owner", int'(bist_ack), int'(e.is_bist));
                    check_output("grant_at_ack", int'(grant), e.is_bist ? 2 : 1);
                    if (e.is_bist) check_output("bist_data", int'(bist_data), int'(e.data));
                    else           check_output("host_data", int'(host_data), int'(e.data));
                end
                acks_seen++;
            end
        end else begin
            prev_rd = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int rd_local;
        int ack_local;
        int base;

        // Reset values, with 0x5A already sitting in the FIFO.
        apply_stimulus(8'h5A);
        #1;
        check_output("rst_read_done", int'(read_done), 0);
        check_output("rst_host_ack", int'(host_ack), 0);
        check_output("rst_bist_ack", int'(bist_ack), 0);
        check_output("rst_bist_mode", int'(bist_mode), 0);
        check_output("rst_grant", int'(grant), 0);
        check_output("rst_pop_count", int'(pop_count), 0);
        check_output("rst_host_data", int'(host_data), 0);
        check_output("rst_bist_data", int'(bist_data), 0);
        steps(3);
        rst_n = 1'b1;
        steps(3);

        // Single host read.
        expect_ack(1'b0, 8'h5A);
        host_req = 1'b1;
        wait_acks(1, 20, "host_first_ack");
        host_req = 1'b0;
        steps(3);
        check_output("pop_count_one", int'(pop_count), 1);
        check_output("host_data_held", int'(host_data), 8'h5A);

        // Requests stall while empty, then complete once data arrives.
        host_req  = 1'b1;
        rd_local  = 0;
        ack_local = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (read_done) rd_local++;
            if (host_ack) ack_local++;
        end
        check_output("empty_no_pop", rd_local, 0);
        check_output("empty_no_ack", ack_local, 0);
        check_output("empty_grant", int'(grant), 0);
        expect_ack(1'b0, 8'h33);
        apply_stimulus(8'h33);
        wait_acks(2, 8, "host_ack_after_fill");
        host_req = 1'b0;
        steps(3);

        // Both requesters with BIST enabled alternate, host first after reset.
        bist_enable = 1'b1;
        do_reset();
        steps(2);
        check_output("bist_mode_set", int'(bist_mode), 1);
        host_req = 1'b1;
        bist_req = 1'b1;
        expect_ack(1'b0, 8'h01);
        expect_ack(1'b1, 8'h02);
        expect_ack(1'b0, 8'h03);
        expect_ack(1'b1, 8'h04);
        for (int i = 1; i <= 4; i++) apply_stimulus(8'(i));
        base = acks_seen;
        wait_acks(base + 4, 60, "alternating_acks");
        check_output("bist_mode_held", int'(bist_mode), 1);
        check_output("pop_count_four", int'(pop_count), 4);
        host_req = 1'b0;
        bist_req = 1'b0;
        steps(3);

        // BIST requests are ignored without BIST mode.
        bist_enable = 1'b0;
        steps(3);
        apply_stimulus(8'h77);
        bist_req  = 1'b1;
        rd_local  = 0;
        ack_local = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (read_done) rd_local++;
            if (bist_ack) ack_local++;
        end
        check_output("bist_off_no_pop", rd_local, 0);
        check_output("bist_off_no_ack", ack_local, 0);
        check_output("bist_off_mode", int'(bist_mode), 0);
        bist_req = 1'b0;

        // Reset in the middle of WAIT aborts without an ack.
        host_req = 1'b1;
        rd_local = 0;
        for (int i = 0; i < 10 && rd_local == 0; i++) begin
            step();
            if (read_done) rd_local++;
        end
        check_output("abort_pop_seen", rd_local, 1);
        step();
        #2;
        rst_n    = 1'b0;
        host_req = 1'b0;
        #1;
        check_output("abort_read_done", int'(read_done), 0);
        check_output("abort_host_ack", int'(host_ack), 0);
        check_output("abort_grant", int'(grant), 0);
        check_output("abort_pop_count", int'(pop_count), 0);
        check_output("abort_host_data", int'(host_data), 0);
        check_output("abort_bist_data", int'(bist_data), 0);
        steps(3);
        rst_n = 1'b1;
        steps(2);
        expect_ack(1'b0, 8'h99);
        apply_stimulus(8'h99);
        host_req = 1'b1;
        base = acks_seen;
        wait_acks(base + 1, 20, "post_abort_ack");
        host_req = 1'b0;
        steps(3);
        check_output("post_abort_pop_count", int'(pop_count), 1);

        // Seventeen back-to-back host pops wrap the 4-bit counter.
        do_reset();
        host_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            expect_ack(1'b0, 8'(8'h10 + i));
            apply_stimulus(8'(8'h10 + i));
        end
        base = acks_seen;
        wait_acks(base + 17, 17 * 7 + 30, "wrap_acks");
        host_req = 1'b0;
        steps(3);
        check_output("pop_count_wrap", int'(pop_count), 1);
        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
